sdram_load_combiner: RTL and testbench

- Sits between the ROM loader's SDRAM byte-write channel and the SDRAM controller's write port, in the ram_clk domain.
- Captures byte writes through a toggle handshake and merges adjacent byte lanes of the same 16-bit word into one write.
- Queues completed words in a small FIFO and issues them to the controller with a level request/pulse acknowledge.
- Halves SDRAM write traffic during ROM load.

---
 rtl/m92_pkg.sv | 32 +++
 rtl/load_word_fifo.sv | 56 +++++
 rtl/sdram_load_combiner.sv | 193 +++++++++++++++++++
 tb/tb_sdram_load_combiner.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/m92_pkg.sv
// Shared types for the SDRAM load combiner: address/data widths, the queued
// word format and the output sequencer states.
package m92_pkg;

    localparam int unsigned SDR_ADDR_W = 25;
    localparam int unsigned SDR_DATA_W = 16;

    // Word-aligned write: byte address bit 0 is implied zero.
    typedef struct packed {
        logic [SDR_ADDR_W-1:1] addr;
        logic [SDR_DATA_W-1:0] data;
        logic [1:0]            be;
    } load_word_t;

    typedef enum logic {
        OUT_IDLE,
        OUT_WAIT
    } out_state_e;

    function automatic logic [SDR_DATA_W-1:0] merge_lanes(
        input logic [SDR_DATA_W-1:0] old_data,
        input logic [SDR_DATA_W-1:0] new_data,
        input logic [1:0]            be
    );
        logic [SDR_DATA_W-1:0] res;
        res = old_data;
        if (be[0]) res[7:0]  = new_data[7:0];
        if (be[1]) res[15:8] = new_data[15:8];
        return res;
    endfunction

endpackage

// File: rtl/load_word_fifo.sv
// Synchronous FIFO of merged SDRAM words; depth must be a power of two so the
// pointers wrap naturally.
module load_word_fifo
    import m92_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  load_word_t wdata_i,
    input  logic       pop_i,
    output load_word_t rdata_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    load_word_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sdram_load_combiner.sv
// Merges loader byte writes into 16-bit SDRAM words, queues them and issues
// them to the controller with a level request / pulse acknowledge.
module sdram_load_combiner
    import m92_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned FLUSH_CYCLES = 64,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                  ram_clk,
    input  logic                  reset,
    input  logic                  load_rq,
    output logic                  load_ack,
    input  logic [SDR_ADDR_W-1:0] load_addr,
    input  logic [SDR_DATA_W-1:0] load_data,
    input  logic [1:0]            load_be,
    input  logic                  flush,
    output logic                  busy,
    output logic [SDR_ADDR_W-1:0] sdr_addr,
    output logic [SDR_DATA_W-1:0] sdr_data,
    output logic [1:0]            sdr_be,
    output logic                  sdr_req,
    input  logic                  sdr_ack
);

    localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FLUSH_CYCLES - 1);

    logic [SYNC_STAGES-1:0] rq_sync_q;
    logic                   rq_s;
    logic                   load_ack_q, load_ack_d;

    logic                  pend_valid_q, pend_valid_d;
    logic [SDR_ADDR_W-1:1] pend_addr_q,  pend_addr_d;
    logic [SDR_DATA_W-1:0] pend_data_q,  pend_data_d;
    logic [1:0]            pend_be_q,    pend_be_d;
    logic                  flush_held_q, flush_held_d;
    logic [CNT_W-1:0]      idle_cnt_q,   idle_cnt_d;

    out_state_e            state_q, state_d;
    logic                  sdr_req_q,  sdr_req_d;
    logic [SDR_ADDR_W-1:0] sdr_addr_q, sdr_addr_d;
    logic [SDR_DATA_W-1:0] sdr_data_q, sdr_data_d;
    logic [1:0]            sdr_be_q,   sdr_be_d;

    logic       outstanding, hit, timeout, nc_push_req, capture, push, pop;
    logic       fifo_full, fifo_empty;
    load_word_t push_word, head_word;
    logic       unused_addr_bit0;

    assign unused_addr_bit0 = load_addr[0];

    assign rq_s        = rq_sync_q[SYNC_STAGES-1];
    assign outstanding = rq_s ^ load_ack_q;
    assign hit         = pend_valid_q && (load_addr[SDR_ADDR_W-1:1] == pend_addr_q);
    assign timeout     = (idle_cnt_q == CNT_MAX);
    assign nc_push_req = pend_valid_q &&
                         ((pend_be_q == 2'b11) || flush || flush_held_q || timeout);
    // Only a miss needs FIFO space; a hit merges even while the FIFO is full.
    assign capture     = outstanding && (!pend_valid_q || hit || !fifo_full);
    assign push        = pend_valid_q && !fifo_full && ((capture && !hit) || nc_push_req);
    assign push_word   = '{addr: pend_addr_q, data: pend_data_q, be: pend_be_q};

    always_comb begin
        load_ack_d   = load_ack_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        pend_be_d    = pend_be_q;
        flush_held_d = (flush_held_q || (flush && pend_valid_q)) && !push;
        idle_cnt_d   = idle_cnt_q;

        if (capture) begin
            load_ack_d   = rq_s;
            pend_valid_d = 1'b1;
            pend_addr_d  = load_addr[SDR_ADDR_W-1:1];
            // A hit that coincides with a push of the old word starts a fresh word.
            if (hit && !push) begin
                pend_data_d = merge_lanes(pend_data_q, load_data, load_be);
                pend_be_d   = pend_be_q | load_be;
            end else begin
                pend_data_d = merge_lanes('0, load_data, load_be);
                pend_be_d   = load_be;
            end
        end else if (push) begin
            pend_valid_d = 1'b0;
            pend_be_d    = '0;
        end

        if (capture || push || !pend_valid_q) begin
            idle_cnt_d = '0;
        end else if (!outstanding && !timeout) begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge ram_clk) begin
        if (reset) begin
            rq_sync_q    <= '0;
            load_ack_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            pend_be_q    <= '0;
            flush_held_q <= 1'b0;
            idle_cnt_q   <= '0;
        end else begin
            rq_sync_q[0] <= load_rq;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                rq_sync_q[i] <= rq_sync_q[i-1];
            end
            load_ack_q   <= load_ack_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            pend_be_q    <= pend_be_d;
            flush_held_q <= flush_held_d;
            idle_cnt_q   <= idle_cnt_d;
        end
    end

    load_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (ram_clk),
        .rst_i   (reset),
        .push_i  (push),
        .wdata_i (push_word),
        .pop_i   (pop),
        .rdata_o (head_word),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        sdr_req_d  = sdr_req_q;
        sdr_addr_d = sdr_addr_q;
        sdr_data_d = sdr_data_q;
        sdr_be_d   = sdr_be_q;
        pop        = 1'b0;

        unique case (state_q)
            OUT_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    sdr_addr_d = {head_word.addr, 1'b0};
                    sdr_data_d = head_word.data;
                    sdr_be_d   = head_word.be;
                    sdr_req_d  = 1'b1;
                    state_d    = OUT_WAIT;
                end
            end
            OUT_WAIT: begin
                if (sdr_ack) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        sdr_addr_d = {head_word.addr, 1'b0};
                        sdr_data_d = head_word.data;
                        sdr_be_d   = head_word.be;
                    end else begin
                        sdr_req_d = 1'b0;
                        state_d   = OUT_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge ram_clk) begin
        if (reset) begin
            state_q    <= OUT_IDLE;
            sdr_req_q  <= 1'b0;
            sdr_addr_q <= '0;
            sdr_data_q <= '0;
            sdr_be_q   <= '0;
        end else begin
            state_q    <= state_d;
            sdr_req_q  <= sdr_req_d;
            sdr_addr_q <= sdr_addr_d;
            sdr_data_q <= sdr_data_d;
            sdr_be_q   <= sdr_be_d;
        end
    end

    assign load_ack = load_ack_q;
    assign sdr_req  = sdr_req_q;
    assign sdr_addr = sdr_addr_q;
    assign sdr_data = sdr_data_q;
    assign sdr_be   = sdr_be_q;
    assign busy     = pend_valid_q | !fifo_empty | sdr_req_q | outstanding;

endmodule

// File: tb/tb_sdram_load_combiner.sv
// Scoreboard bench: a byte/word-level model predicts SDRAM writes, a monitor
// compares every accepted write against the queue of predictions.
module tb_sdram_load_combiner;

    logic        ram_clk = 1'b0;
    logic        reset, load_rq, load_ack, flush, busy, sdr_req;
    logic        sdr_ack = 1'b0;
    logic [24:0] load_addr, sdr_addr;
    logic [15:0] load_data, sdr_data;
    logic [1:0]  load_be, sdr_be;

    always #5 ram_clk = ~ram_clk;

    sdram_load_combiner #(
        .FIFO_DEPTH   (8),
        .FLUSH_CYCLES (64),
        .SYNC_STAGES  (2)
    ) dut (
        .ram_clk   (ram_clk),
        .reset     (reset),
        .load_rq   (load_rq),
        .load_ack  (load_ack),
        .load_addr (load_addr),
        .load_data (load_data),
        .load_be   (load_be),
        .flush     (flush),
        .busy      (busy),
        .sdr_addr  (sdr_addr),
        .sdr_data  (sdr_data),
        .sdr_be    (sdr_be),
        .sdr_req   (sdr_req),
        .sdr_ack   (sdr_ack)
    );

    typedef struct {
        logic [24:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } wr_t;

    int unsigned vectors = 0, miscompares = 0, cycle = 0, writes_seen = 0;
    wr_t         exp_q[$];
    wr_t         mon_e;
    bit          ack_en = 1'b0;

    // Reference model: the word currently being assembled.
    bit          m_valid = 1'b0;
    logic [23:0] m_word;
    logic [15:0] m_data;
    logic [1:0]  m_be;

    always @(posedge ram_clk) cycle++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lane_mask(input logic [1:0] be);
        return {{8{be[1]}}, {8{be[0]}}};
    endfunction

    function automatic void m_push();
        wr_t w;
        w.addr = {m_word, 1'b0};
        w.data = m_data;
        w.be   = m_be;
        exp_q.push_back(w);
        m_valid = 1'b0;
    endfunction

    function automatic void m_byte(input logic [24:0] a, input logic [15:0] d, input logic [1:0] be);
        if (m_valid && a[24:1] != m_word) m_push();
        if (!m_valid) begin
            m_valid = 1'b1;
            m_word  = a[24:1];
            m_data  = '0;
            m_be    = '0;
        end
        if (be[0]) m_data[7:0]  = d[7:0];
        if (be[1]) m_data[15:8] = d[15:8];
        m_be = m_be | be;
        if (m_be == 2'b11) m_push();
    endfunction

    function automatic void m_flush();
        if (m_valid) m_push();
    endfunction

    // Controller model: one-cycle accept pulses at random delays.
    always @(posedge ram_clk) begin
        #1;
        if (reset || sdr_ack) sdr_ack = 1'b0;
        else if (sdr_req && ack_en && $urandom_range(0, 2) == 0) sdr_ack = 1'b1;
    end

    always @(negedge ram_clk) begin
        if (!reset && sdr_req && sdr_ack) begin
            writes_seen++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h be %b expected none",
                         sdr_addr, sdr_data, sdr_be);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(sdr_addr), 32'(mon_e.addr));
                chk("wr_be", 32'(sdr_be), 32'(mon_e.be));
                chk("wr_data", 32'(sdr_data & lane_mask(mon_e.be)),
                    32'(mon_e.data & lane_mask(mon_e.be)));
            end
        end
    end

    task automatic issue(input logic [24:0] a, input logic [15:0] d, input logic [1:0] be);
        @(negedge ram_clk);
        load_addr = a;
        load_data = d;
        load_be   = be;
        load_rq   = ~load_rq;
        m_byte(a, d, be);
    endtask

    task automatic wait_ack(input int unsigned limit, output bit ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < limit; i++) begin
            @(negedge ram_clk);
            if (load_ack == load_rq) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [15:0] d, input logic [1:0] be);
        bit ok;
        issue(a, d, be);
        wait_ack(100, ok);
        chk("load_ack_toggle", 32'(load_ack), 32'(load_rq));
    endtask

    task automatic pulse_flush();
        @(negedge ram_clk);
        flush = 1'b1;
        m_flush();
        @(negedge ram_clk);
        flush = 1'b0;
    endtask

    task automatic drain(input int unsigned limit);
        for (int unsigned i = 0; i < limit; i++) begin
            @(negedge ram_clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        chk("drain_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          ok, stalled, seen_req;
        int unsigned t0, w0;
        logic [24:0] a;
        logic [7:0]  b;
        logic [1:0]  be;

        reset = 1'b1; load_rq = 1'b0; flush = 1'b0;
        load_addr = '0; load_data = '0; load_be = '0;
        repeat (3) @(negedge ram_clk);
        reset = 1'b0;
        chk("rst_load_ack", 32'(load_ack), 32'd0);
        chk("rst_sdr_req", 32'(sdr_req), 32'd0);
        chk("rst_sdr_addr", 32'(sdr_addr), 32'd0);
        chk("rst_sdr_data", 32'(sdr_data), 32'd0);
        chk("rst_sdr_be", 32'(sdr_be), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        ack_en = 1'b1;

        // Adjacent lanes merge; request appears on the second edge after capture.
        send_byte(25'h000100, 16'h00AA, 2'b01);
        send_byte(25'h000101, 16'hBB00, 2'b10);
        @(negedge ram_clk);
        chk("merge_req_early", 32'(sdr_req), 32'd0);
        @(negedge ram_clk);
        chk("merge_req_latency", 32'(sdr_req), 32'd1);
        drain(200);

        // Miss emits the first byte; the second leaves only by idle timeout.
        send_byte(25'h000200, 16'h0011, 2'b01);
        send_byte(25'h000400, 16'h0044, 2'b01);
        t0 = cycle;
        m_flush();
        drain(400);
        chk("timeout_not_early", 32'(cycle - t0 >= 64), 32'd1);

        send_byte(25'h000300, 16'hCC00, 2'b10);
        pulse_flush();
        seen_req = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (sdr_req) begin
                seen_req = 1'b1;
                break;
            end
            @(negedge ram_clk);
        end
        chk("flush_latency", 32'(seen_req), 32'd1);
        drain(100);

        // Same lane twice: last write wins.
        send_byte(25'h000500, 16'h0011, 2'b01);
        send_byte(25'h000500, 16'h0022, 2'b01);
        send_byte(25'h000501, 16'h3300, 2'b10);
        drain(200);

        // Fill: one word at the output, eight in the FIFO, one pending.
        ack_en  = 1'b0;
        stalled = 1'b0;
        for (int unsigned i = 0; i < 20; i++) begin
            issue(25'h010000 + 25'(2 * i), 16'h0101 * 16'(i + 1), (i % 2 == 0) ? 2'b01 : 2'b10);
            wait_ack(40, ok);
            if (!ok && !stalled) begin
                stalled = 1'b1;
                chk("stall_index", i, 32'd10);
                ack_en = 1'b1;
                wait_ack(500, ok);
            end
            chk("fill_ack", 32'(ok), 32'd1);
        end
        chk("stall_seen", 32'(stalled), 32'd1);
        pulse_flush();
        drain(1000);

        for (int unsigned i = 0; i < 150; i++) begin
            a  = {8'h00, 16'h8000 + 16'($urandom_range(0, 3)), 1'($urandom_range(0, 1))};
            b  = 8'($urandom);
            be = a[0] ? 2'b10 : 2'b01;
            send_byte(a, {b, b}, be);
            if ($urandom_range(0, 15) == 0) pulse_flush();
        end
        pulse_flush();
        drain(1000);

        // Reset with three words queued abandons everything.
        ack_en = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            send_byte(25'h020000 + 25'(4 * i), 16'h5A5A, 2'b01);
        end
        repeat (4) @(negedge ram_clk);
        chk("pre_reset_req", 32'(sdr_req), 32'd1);
        reset   = 1'b1;
        load_rq = 1'b0;
        exp_q.delete();
        m_valid = 1'b0;
        @(negedge ram_clk);
        reset = 1'b0;
        chk("post_reset_req", 32'(sdr_req), 32'd0);
        chk("post_reset_busy", 32'(busy), 32'd0);
        chk("post_reset_ack", 32'(load_ack), 32'd0);
        ack_en = 1'b1;
        w0 = writes_seen;
        repeat (100) @(negedge ram_clk);
        chk("post_reset_writes", writes_seen - w0, 32'd0);
        chk("post_reset_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
